// File: rtl/spi_slave_port.sv
// SPI target with every pin oversampled in the clk domain. Each word runs one
// LOAD/SHIFT pass, and words follow back-to-back while spi_ss_n stays low.
module spi_slave_port #(
    parameter int WORD_W = 32,
    parameter int SYNC_N = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cpol,
    input  logic              cpha,
    input  logic              lsb_first,
    input  logic              spi_sck,
    input  logic              spi_mosi,
    input  logic              spi_ss_n,
    output logic              spi_miso,
    output logic              spi_miso_oe,
    input  logic [WORD_W-1:0] tx_data,
    input  logic              tx_valid,
    output logic              tx_ready,
    output logic [WORD_W-1:0] rx_data,
    output logic              rx_valid,
    input  logic              rx_ready,
    output logic              tx_underrun,
    output logic              rx_overrun,
    output logic              busy
);
    localparam int               CNT_W = $clog2(WORD_W);
    localparam logic [CNT_W-1:0] LAST  = CNT_W'(WORD_W - 1);

    typedef enum logic [1:0] {IDLE, LOAD, SHIFT} state_t;
    state_t state_q, state_d;

    logic [SYNC_N-1:0] sck_sync_q, mosi_sync_q, ss_sync_q;
    logic              sck_dly_q;
    logic              sck_s, mosi_s, ss_s;
    logic              sck_rise, sck_fall, lead_edge, trail_edge, sample_edge, shift_edge;

    logic              cpol_q, cpol_d, cpha_q, cpha_d, lsb_q, lsb_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [WORD_W-1:0] rx_sr_q, rx_sr_d, tx_word_q, tx_word_d;
    logic [WORD_W-1:0] hold_q, hold_d, rx_data_q, rx_data_d;
    logic              hold_full_q, hold_full_d, rx_valid_q, rx_valid_d;
    logic              miso_q, miso_d, und_q, und_d, ovr_q, ovr_d;

    // Bit n of the word in transmit order.
    function automatic logic pick(input logic [WORD_W-1:0] w, input logic [CNT_W-1:0] n,
                                  input logic lsb);
        return lsb ? w[n] : w[LAST - n];
    endfunction

    assign sck_s  = sck_sync_q[SYNC_N-1];
    assign mosi_s = mosi_sync_q[SYNC_N-1];
    assign ss_s   = ss_sync_q[SYNC_N-1];

    assign sck_rise    = sck_s & ~sck_dly_q;
    assign sck_fall    = ~sck_s & sck_dly_q;
    assign lead_edge   = cpol_q ? sck_fall : sck_rise;
    assign trail_edge  = cpol_q ? sck_rise : sck_fall;
    assign sample_edge = cpha_q ? trail_edge : lead_edge;
    assign shift_edge  = cpha_q ? lead_edge : trail_edge;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sck_sync_q  <= '0;
            mosi_sync_q <= '0;
            ss_sync_q   <= '1;
            sck_dly_q   <= 1'b0;
        end else begin
            sck_sync_q  <= {sck_sync_q[SYNC_N-2:0], spi_sck};
            mosi_sync_q <= {mosi_sync_q[SYNC_N-2:0], spi_mosi};
            ss_sync_q   <= {ss_sync_q[SYNC_N-2:0], spi_ss_n};
            sck_dly_q   <= sck_s;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            cpol_q      <= 1'b0;
            cpha_q      <= 1'b0;
            lsb_q       <= 1'b0;
            cnt_q       <= '0;
            rx_sr_q     <= '0;
            tx_word_q   <= '0;
            hold_q      <= '0;
            hold_full_q <= 1'b0;
            rx_data_q   <= '0;
            rx_valid_q  <= 1'b0;
            miso_q      <= 1'b0;
            und_q       <= 1'b0;
            ovr_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            cpol_q      <= cpol_d;
            cpha_q      <= cpha_d;
            lsb_q       <= lsb_d;
            cnt_q       <= cnt_d;
            rx_sr_q     <= rx_sr_d;
            tx_word_q   <= tx_word_d;
            hold_q      <= hold_d;
            hold_full_q <= hold_full_d;
            rx_data_q   <= rx_data_d;
            rx_valid_q  <= rx_valid_d;
            miso_q      <= miso_d;
            und_q       <= und_d;
            ovr_q       <= ovr_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        cpol_d      = cpol_q;
        cpha_d      = cpha_q;
        lsb_d       = lsb_q;
        cnt_d       = cnt_q;
        rx_sr_d     = rx_sr_q;
        tx_word_d   = tx_word_q;
        hold_d      = hold_q;
        hold_full_d = hold_full_q;
        rx_data_d   = rx_data_q;
        rx_valid_d  = rx_valid_q;
        miso_d      = miso_q;
        und_d       = 1'b0;
        ovr_d       = 1'b0;

        if (tx_valid && !hold_full_q) begin
            hold_d      = tx_data;
            hold_full_d = 1'b1;
        end
        if (rx_valid_q && rx_ready) rx_valid_d = 1'b0;

        // Deselect aborts the frame from any state; the holding register survives.
        if (state_q != IDLE && ss_s) begin
            state_d   = IDLE;
            cnt_d     = '0;
            rx_sr_d   = '0;
            tx_word_d = '0;
            miso_d    = 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (!ss_s) begin
                        state_d = LOAD;
                        cpol_d  = cpol;
                        cpha_d  = cpha;
                        lsb_d   = lsb_first;
                        cnt_d   = '0;
                    end
                end
                LOAD: begin
                    if (hold_full_q) begin
                        tx_word_d   = hold_q;
                        hold_full_d = 1'b0;
                    end else begin
                        tx_word_d = '0;
                        und_d     = 1'b1;
                    end
                    miso_d  = pick(tx_word_d, '0, lsb_q);
                    cnt_d   = '0;
                    state_d = SHIFT;
                end
                SHIFT: begin
                    if (sample_edge) begin
                        rx_sr_d = lsb_q ? {mosi_s, rx_sr_q[WORD_W-1:1]}
                                        : {rx_sr_q[WORD_W-2:0], mosi_s};
                        if (cnt_q == LAST) begin
                            cnt_d   = '0;
                            state_d = LOAD;
                            if (rx_valid_q && !rx_ready) begin
                                ovr_d = 1'b1;
                            end else begin
                                rx_data_d  = rx_sr_d;
                                rx_valid_d = 1'b1;
                            end
                        end else begin
                            cnt_d = cnt_q + 1'b1;
                        end
                    end else if (shift_edge) begin
                        // Index by samples taken, so the cpha=1 first shift edge re-presents bit 0.
                        miso_d = pick(tx_word_q, cnt_q, lsb_q);
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    assign spi_miso    = miso_q;
    assign busy        = (state_q != IDLE);
    assign spi_miso_oe = busy;
    assign tx_ready    = ~hold_full_q;
    assign rx_data     = rx_data_q;
    assign rx_valid    = rx_valid_q;
    assign tx_underrun = und_q;
    assign rx_overrun  = ovr_q;
endmodule

// File: tb/tb_spi_slave_port.sv
// Randomized bench for spi_slave_port: a pin-level SPI master plus a word-level
// model (expected MISO word = loaded tx word or 0, expected rx word = MOSI word).
module tb_spi_slave_port;
    localparam int HALF = 6;

    logic        clk = 1'b0;
    logic        rst;
    logic        cpol, cpha, lsb_first, spi_sck, spi_mosi, spi_ss_n;
    logic        spi_miso, spi_miso_oe, tx_valid, tx_ready, rx_valid, rx_ready;
    logic        tx_underrun, rx_overrun, busy;
    logic [31:0] tx_data, rx_data;

    int          n_tests = 0;
    int          n_fail = 0;
    int          und_cnt = 0;
    int          ovr_cnt = 0;
    logic [31:0] refill_q[$];

    always #5 clk = ~clk;

    spi_slave_port #(.WORD_W(32), .SYNC_N(2)) dut (
        .clk(clk), .rst(rst), .cpol(cpol), .cpha(cpha), .lsb_first(lsb_first),
        .spi_sck(spi_sck), .spi_mosi(spi_mosi), .spi_ss_n(spi_ss_n),
        .spi_miso(spi_miso), .spi_miso_oe(spi_miso_oe),
        .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
        .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
        .tx_underrun(tx_underrun), .rx_overrun(rx_overrun), .busy(busy)
    );

    always @(negedge clk) begin
        if (tx_underrun) und_cnt++;
        if (rx_overrun) ovr_cnt++;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic push_tx(input logic [31:0] w);
        chk("tx_ready_pre", tx_ready, 1);
        tx_data  = w;
        tx_valid = 1'b1;
        tick(1);
        tx_valid = 1'b0;
        chk("tx_ready_post", tx_ready, 0);
    endtask

    task automatic frame_begin(input bit pol, input bit pha, input bit lsb);
        cpol = pol; cpha = pha; lsb_first = lsb;
        spi_sck = pol;
        tick(6);
        spi_ss_n = 1'b0;
        tick(8);
    endtask

    task automatic frame_end();
        tick(HALF);
        spi_ss_n = 1'b1;
        tick(10);
    endtask

    // Master side of one word (or its first nbits); refills tx during bit 2.
    task automatic xfer(input logic [31:0] mo, input int nbits, output logic [31:0] mi);
        int idx;
        mi = '0;
        for (int i = 0; i < nbits; i++) begin
            idx = lsb_first ? i : 31 - i;
            if (i == 2 && refill_q.size() > 0) begin
                tx_data  = refill_q.pop_front();
                tx_valid = 1'b1;
            end
            if (i == 3) tx_valid = 1'b0;
            if (!cpha) begin
                spi_mosi = mo[idx];
                tick(HALF);
                mi[idx] = spi_miso;
                spi_sck = ~cpol;
                tick(HALF);
                spi_sck = cpol;
            end else begin
                spi_sck  = ~cpol;
                spi_mosi = mo[idx];
                tick(HALF);
                mi[idx] = spi_miso;
                spi_sck = cpol;
                tick(HALF);
            end
        end
        tx_valid = 1'b0;
    endtask

    task automatic take_rx(input string tag, input logic [31:0] exp);
        int t = 0;
        while (!rx_valid && t < 40) begin
            tick(1);
            t++;
        end
        chk({tag, "_vld"}, rx_valid, 1);
        chk({tag, "_data"}, rx_data, exp);
        rx_ready = 1'b1;
        tick(1);
        rx_ready = 1'b0;
        chk({tag, "_clr"}, rx_valid, 0);
    endtask

    initial begin
        logic [31:0] mi, w0, w1, w2, m0, m1, m2;
        int u0, o0, nw;
        rst = 1'b1; cpol = 0; cpha = 0; lsb_first = 0;
        spi_sck = 0; spi_mosi = 0; spi_ss_n = 1;
        tx_data = '0; tx_valid = 0; rx_ready = 0;
        tick(3);
        chk("rst_miso", spi_miso, 0);
        chk("rst_oe", spi_miso_oe, 0);
        chk("rst_tx_ready", tx_ready, 1);
        chk("rst_rx_valid", rx_valid, 0);
        chk("rst_rx_data", rx_data, 0);
        chk("rst_busy", busy, 0);
        chk("rst_pulses", {tx_underrun, rx_overrun}, 0);
        rst = 1'b0;
        tick(3);

        // Mode 0, MSB first.
        push_tx(32'hA5A5_0F0F);
        frame_begin(0, 0, 0);
        chk("m0_busy", busy, 1);
        chk("m0_oe", spi_miso_oe, 1);
        chk("m0_tx_ready", tx_ready, 1);
        xfer(32'h1234_5678, 32, mi);
        chk("m0_miso", mi, 32'hA5A5_0F0F);
        take_rx("m0_rx", 32'h1234_5678);
        frame_end();
        chk("m0_idle_busy", busy, 0);
        chk("m0_idle_oe", spi_miso_oe, 0);
        chk("m0_idle_miso", spi_miso, 0);

        // Mode 3, LSB first.
        push_tx(32'h8000_0001);
        frame_begin(1, 1, 1);
        xfer(32'h0000_00FF, 32, mi);
        chk("m3_miso", mi, 32'h8000_0001);
        take_rx("m3_rx", 32'h0000_00FF);
        frame_end();

        // Three back-to-back words with refill; a spare word covers the trailing LOAD.
        w0 = $urandom(); w1 = $urandom(); w2 = $urandom();
        m0 = $urandom(); m1 = $urandom(); m2 = $urandom();
        push_tx(w0);
        refill_q = '{w1, w2, 32'h0};
        u0 = und_cnt; o0 = ovr_cnt;
        frame_begin(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        xfer(m0, 32, mi); chk("b2b_miso0", mi, w0); take_rx("b2b_rx0", m0);
        xfer(m1, 32, mi); chk("b2b_miso1", mi, w1); take_rx("b2b_rx1", m1);
        xfer(m2, 32, mi); chk("b2b_miso2", mi, w2); take_rx("b2b_rx2", m2);
        frame_end();
        chk("b2b_underrun", und_cnt - u0, 0);
        chk("b2b_overrun", ovr_cnt - o0, 0);

        // Underrun: nothing loaded before the frame.
        m0 = $urandom();
        u0 = und_cnt;
        frame_begin(0, 1, 0);
        chk("ur_pulse", und_cnt - u0, 1);
        xfer(m0, 32, mi);
        chk("ur_miso", mi, 0);
        take_rx("ur_rx", m0);
        frame_end();

        // Overrun: consumer stalled across two words.
        w0 = $urandom(); w1 = $urandom(); m0 = $urandom(); m1 = $urandom();
        push_tx(w0);
        refill_q = '{w1, 32'h0};
        o0 = ovr_cnt;
        frame_begin(0, 0, 1);
        xfer(m0, 32, mi); chk("ov_miso0", mi, w0);
        xfer(m1, 32, mi); chk("ov_miso1", mi, w1);
        tick(6);
        chk("ov_pulse", ovr_cnt - o0, 1);
        chk("ov_keep", rx_data, m0);
        frame_end();
        take_rx("ov_rx", m0);

        // Partial word discarded, then a full frame.
        push_tx($urandom());
        frame_begin(1, 0, 0);
        xfer($urandom(), 13, mi);
        frame_end();
        chk("part_rx_valid", rx_valid, 0);
        chk("part_tx_ready", tx_ready, 1);
        w0 = $urandom();
        push_tx(w0);
        frame_begin(1, 0, 0);
        xfer(32'hDEAD_BEEF, 32, mi);
        chk("part_miso", mi, w0);
        take_rx("part_rx", 32'hDEAD_BEEF);
        frame_end();

        // Random frames of one or two words in random modes.
        for (int it = 0; it < 4; it++) begin
            nw = $urandom_range(1, 2);
            w0 = $urandom(); w1 = $urandom();
            push_tx(w0);
            refill_q = (nw == 2) ? '{w1, 32'h0} : '{32'h0};
            frame_begin(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            for (int k = 0; k < nw; k++) begin
                m0 = $urandom();
                xfer(m0, 32, mi);
                chk("rnd_miso", mi, (k == 0) ? w0 : w1);
                take_rx("rnd_rx", m0);
            end
            frame_end();
        end

        // Reset mid-frame with an unread word pending.
        push_tx($urandom());
        frame_begin(0, 0, 0);
        xfer($urandom(), 32, mi);
        xfer($urandom(), 5, mi);
        rst = 1'b1;
        tick(1);
        chk("mrst_busy", busy, 0);
        chk("mrst_oe", spi_miso_oe, 0);
        chk("mrst_miso", spi_miso, 0);
        chk("mrst_rx_valid", rx_valid, 0);
        chk("mrst_rx_data", rx_data, 0);
        chk("mrst_tx_ready", tx_ready, 1);
        spi_ss_n = 1'b1;
        tick(2);
        rst = 1'b0;
        tick(4);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
